// File: rtl/div_pkg.sv
// Shared types for the dual-pipe divider controller: op encoding, FSM states, default sizing.
package div_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_BITS_PER_CYCLE = 1;
  localparam int DIV_ITERS          = DEF_DATA_WIDTH / DEF_BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    MOD  = 2'd2,
    MODU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic op_is_signed(div_op_t op);
    return (op == DIV) || (op == MOD);
  endfunction

  function automatic logic op_is_rem(div_op_t op);
    return (op == MOD) || (op == MODU);
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring shift-subtract divider on unsigned magnitudes; retires BITS_PER_CYCLE quotient bits per step.
module div_iter_core
  import div_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  logic [DATA_WIDTH-1:0] q_q, r_q, d_q;
  logic [DATA_WIDTH-1:0] q_nxt, r_nxt;
  logic [DATA_WIDTH:0]   trial;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  // NOTE: blocking assignments here are deliberate: each unrolled bit feeds the next within one cycle.
  always_comb begin
    q_nxt = q_q;
    r_nxt = r_q;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {r_nxt, q_nxt[DATA_WIDTH-1]};
      q_nxt = {q_nxt[DATA_WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, d_q}) begin
        trial    = trial - {1'b0, d_q};
        q_nxt[0] = 1'b1;
      end
      r_nxt = trial[DATA_WIDTH-1:0];
    end
  end

  // NOTE: the datapath registers are reset as well so nothing downstream ever sees X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
    end else if (start) begin
      q_q <= dividend;
      r_q <= '0;
      d_q <= divisor;
    end else if (step) begin
      q_q <= q_nxt;
      r_q <= r_nxt;
    end
  end

  assign quotient  = q_q;
  assign remainder = r_q;

endmodule

// File: rtl/dual_pipe_div_ctrl.sv
// Shares one iterative divider between pipes 0 and 1: oldest-first grant, EX stalls, sign fix, response hold.
// Optional: define DIV_EARLY_OUT_EN to skip iterations when divisor is zero or |a| < |b|.
module dual_pipe_div_ctrl
  import div_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid_i,
  input  div_op_t [1:0]              req_op_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_a_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_b_i,
  input  logic                       older_i,
  input  logic [1:0]                 req_kill_i,
  input  logic [1:0]                 ex_adv_i,
  output logic [1:0]                 stall_req_o,
  output logic [1:0]                 resp_valid_o,
  output logic [1:0][DATA_WIDTH-1:0] resp_data_o
);

  localparam int ITERS = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  function automatic logic [DATA_WIDTH-1:0] magnitude(logic [DATA_WIDTH-1:0] v, logic sgn);
    return (sgn && v[DATA_WIDTH-1]) ? -v : v;
  endfunction

  div_state_t            state_q;
  logic                  owner_q;
  div_op_t               op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  early_q;

  logic [1:0]            live;
  logic                  grant_pipe, grant_en, early_go;
  div_op_t               g_op;
  logic [DATA_WIDTH-1:0] g_a, g_b, g_amag, g_bmag;
  logic                  owner_kill, owner_adv;
  logic [DATA_WIDTH-1:0] core_q, core_r, fix_res;

  // Arbitration: older pipe wins a tie; a request killed this cycle is not live.
  always_comb begin
    live       = req_valid_i & ~req_kill_i;
    grant_pipe = (live == 2'b11) ? older_i : live[1];
    grant_en   = (state_q == IDLE) && (live != 2'b00);
    g_op       = req_op_i[grant_pipe];
    g_a        = req_a_i[grant_pipe];
    g_b        = req_b_i[grant_pipe];
    g_amag     = magnitude(g_a, op_is_signed(g_op));
    g_bmag     = magnitude(g_b, op_is_signed(g_op));
`ifdef DIV_EARLY_OUT_EN
    early_go   = (g_b == '0) || (g_amag < g_bmag);
`else
    early_go   = 1'b0;
`endif
  end

  assign owner_kill = req_kill_i[owner_q];
  assign owner_adv  = ex_adv_i[owner_q];

  div_iter_core #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (grant_en && !early_go),
    .step      (state_q == BUSY),
    .dividend  (g_amag),
    .divisor   (g_bmag),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // Sign correction; an early-out op has quotient 0 and remainder |a| without iterating.
  always_comb begin
    logic                  sgn, a_neg, b_neg;
    logic [DATA_WIDTH-1:0] q_mag, r_mag, quo, rem;
    sgn   = op_is_signed(op_q);
    a_neg = sgn & a_q[DATA_WIDTH-1];
    b_neg = sgn & b_q[DATA_WIDTH-1];
    q_mag = early_q ? '0 : core_q;
    r_mag = early_q ? magnitude(a_q, sgn) : core_r;
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end
    fix_res = op_is_rem(op_q) ? rem : quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= DIV;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      early_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (grant_en) begin
          owner_q <= grant_pipe;
          op_q    <= g_op;
          a_q     <= g_a;
          b_q     <= g_b;
          cnt_q   <= '0;
          early_q <= early_go;
          state_q <= early_go ? FIX : BUSY;
        end
        BUSY: begin
          if (owner_kill)              state_q <= IDLE;
          else if (cnt_q == LAST_ITER) state_q <= FIX;
          else                         cnt_q   <= cnt_q + 1'b1;
        end
        FIX: begin
          if (owner_kill) begin
            state_q <= IDLE;
          end else begin
            res_q   <= fix_res;
            state_q <= DONE;
          end
        end
        DONE:    if (owner_kill || owner_adv) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A kill in DONE suppresses the response in that same cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      resp_valid_o[p] = (state_q == DONE) && (owner_q == 1'(p)) && !req_kill_i[p];
      resp_data_o[p]  = resp_valid_o[p] ? res_q : '0;
      stall_req_o[p]  = req_valid_i[p] && !req_kill_i[p] &&
                        !((state_q == DONE) && (owner_q == 1'(p)));
    end
  end

endmodule

// File: tb/tb_dual_pipe_div_ctrl.sv
// Randomised and directed bench for dual_pipe_div_ctrl against an arithmetic reference model.
module tb_dual_pipe_div_ctrl;
  import div_pkg::*;

  localparam int DW       = 32;
  localparam int LAT_FULL = DW + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid, req_kill, ex_adv, stall, resp_valid;
  logic                older;
  div_op_t [1:0]       req_op;
  logic [1:0][DW-1:0]  req_a, req_b, resp_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dual_pipe_div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .older_i      (older),
    .req_kill_i   (req_kill),
    .ex_adv_i     (ex_adv),
    .stall_req_o  (stall),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic plus the two documented special cases.
  function automatic logic [31:0] ref_result(div_op_t op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return (op == MOD || op == MODU) ? a : 32'hFFFF_FFFF;
    if ((op == DIV || op == MOD) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == DIV) ? a : 32'd0;
    case (op)
      DIV:     return 32'(sa / sb);
      MOD:     return 32'(sa % sb);
      DIVU:    return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_lat(div_op_t op, logic [31:0] a, logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    longint ma, mb;
    ma = (op == DIV || op == MOD) ? longint'($signed(a)) : longint'(a);
    mb = (op == DIV || op == MOD) ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 32'd0 || ma < mb) return 2;
`endif
    return LAT_FULL;
  endfunction

  // Starts at posedge+1 (grant cycle T) and returns at posedge+1 of the cycle after release.
  task automatic do_op(input int p, input div_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input string tag);
    int          cyc, lat;
    logic [31:0] exp_d;
    logic        stall_ok;
    exp_d    = ref_result(op, a, b);
    lat      = exp_lat(op, a, b);
    stall_ok = 1'b1;
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_a[p]     = a;
    req_b[p]     = b;
    ex_adv[p]    = (hold == 0);
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (resp_valid[p]) break;
      stall_ok = stall_ok & stall[p];
    end
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_data"}, 64'(resp_data[p]), 64'(exp_d));
    check({tag, "_stall_wait"}, 64'(stall_ok), 64'd1);
    check({tag, "_stall_done"}, 64'(stall[p]), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold"}, {31'd0, resp_valid[p], resp_data[p]}, {31'd0, 1'b1, exp_d});
    end
    ex_adv[p] = 1'b1;
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    ex_adv       = 2'b11;
    @(negedge clk);
    check({tag, "_release"}, {31'd0, resp_valid[p], resp_data[p]}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0, t1, l0, l1;
    logic [31:0] d0, d1, a, b;
    logic        seen, ok;
    div_op_t     op;

    rst       = 1'b1;
    req_valid = 2'b00;
    req_kill  = 2'b00;
    ex_adv    = 2'b11;
    older     = 1'b0;
    req_op[0] = DIV;
    req_op[1] = DIV;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {stall, resp_valid, resp_data}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, DIV,  32'd100,       32'd7,         0, "div_100_7");
    do_op(1, MOD,  32'hFFFF_FFF9, 32'd2,         0, "mod_m7_2");
    do_op(1, MODU, 32'hFFFF_FFF9, 32'd2,         0, "modu");
    do_op(0, DIV,  32'd5,         32'd0,         0, "div_by0");
    do_op(1, MOD,  32'd5,         32'd0,         0, "mod_by0");
    do_op(0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, "intmin");
    do_op(1, DIVU, 32'd3,         32'd9,         0, "divu_early");
    do_op(0, DIV,  32'hFFFF_FF9C, 32'd7,         3, "hold3");

    // Both pipes request together; pipe1 is older and goes first.
    older     = 1'b1;
    req_valid = 2'b11;
    req_op[0] = DIV; req_a[0] = 32'd1000;       req_b[0] = 32'd7;
    req_op[1] = DIV; req_a[1] = 32'hFFFF_FF9C;  req_b[1] = 32'd9;
    l1 = exp_lat(DIV, 32'hFFFF_FF9C, 32'd9);
    l0 = exp_lat(DIV, 32'd1000, 32'd7);
    t0 = -1; t1 = -1; d0 = '0; d1 = '0; ok = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (resp_valid[1] && t1 < 0) begin t1 = c; d1 = resp_data[1]; end
      if (resp_valid[0] && t0 < 0) begin t0 = c; d0 = resp_data[0]; end
      if (t0 >= 0) break;
      ok = ok & stall[0];
      @(posedge clk); #1;
      if (t1 >= 0) req_valid[1] = 1'b0;
    end
    check("both_p1_time", 64'(t1), 64'(l1));
    check("both_p1_data", 64'(d1), 64'(ref_result(DIV, 32'hFFFF_FF9C, 32'd9)));
    check("both_p0_time", 64'(t0), 64'(l1 + 1 + l0));
    check("both_p0_data", 64'(d0), 64'(ref_result(DIV, 32'd1000, 32'd7)));
    check("both_p0_stall", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    older     = 1'b0;
    @(posedge clk); #1;

    // Owner killed at T+10; a fresh request at T+11 must be granted straight away.
    req_valid[0] = 1'b1; req_op[0] = DIV; req_a[0] = 32'd1000; req_b[0] = 32'd3;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      seen = seen | resp_valid[0];
      @(posedge clk); #1;
    end
    req_kill[0] = 1'b1;
    @(negedge clk);
    seen = seen | resp_valid[0];
    check("kill_stall", 64'(stall[0]), 64'd0);
    check("kill_no_resp", 64'(seen), 64'd0);
    @(posedge clk); #1;
    req_kill[0] = 1'b0;
    do_op(0, DIV, 32'd1234, 32'd11, 0, "after_kill");

    // Kill in the grant cycle: no grant, never a response.
    req_valid[1] = 1'b1; req_kill[1] = 1'b1; req_op[1] = DIVU; req_a[1] = 32'd50; req_b[1] = 32'd5;
    @(negedge clk);
    check("grant_kill_stall", 64'(stall[1]), 64'd0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_kill[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen = seen | (|resp_valid);
    end
    check("grant_kill_no_resp", 64'(seen), 64'd0);
    @(posedge clk); #1;
    do_op(1, DIVU, 32'd50, 32'd5, 0, "post_grant_kill");

    // Reset mid-operation aborts silently.
    req_valid[0] = 1'b1; req_op[0] = MOD; req_a[0] = 32'd77; req_b[0] = 32'd5;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("midop_reset", {stall, resp_valid, resp_data}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(0, MOD, 32'd77, 32'd5, 0, "post_reset");

    for (int i = 0; i < 30; i++) begin
      op = div_op_t'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       begin a = $urandom; b = $urandom; end
        1:       begin a = $urandom; b = $urandom_range(1, 20); if ($urandom_range(0, 1) == 1) b = -b; end
        2:       begin a = $urandom_range(0, 50); b = $urandom_range(51, 1000); end
        3:       begin a = $urandom; b = 32'd0; end
        default: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      endcase
      do_op($urandom_range(0, 1), op, a, b, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
